dequantization: RTL and testbench

//  Inverse of the quantization stage. Maps a pair of quantized level indices (vqx, vqy) in 0..L-1

---
 rtl/dequantization.sv | 183 ++++++++++++++++++
 tb/tb_dequantization.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dequantization.sv
// Dequantizer: maps a pair of level indices back to bin-centre values in [-M, M]
// using two parallel MSB-first restoring dividers; one pair in flight at a time.
module dequantization #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 6
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] M,
    input  logic signed [DATA_WIDTH-1:0] vqx,
    input  logic signed [DATA_WIDTH-1:0] vqy,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] vdx,
    output logic signed [DATA_WIDTH-1:0] vdy,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int NW = 2 * DATA_WIDTH;
    localparam int RW = $clog2(L) + 1;
    localparam int CW = $clog2(NW);

    localparam logic [RW-1:0]                L_DIV    = RW'(L);
    localparam logic signed [DATA_WIDTH-1:0] L_LVL    = DATA_WIDTH'(L);
    localparam logic [DATA_WIDTH-1:0]        L_TOP    = DATA_WIDTH'(L - 1);
    localparam logic [CW-1:0]                CNT_LAST = CW'(NW - 1);
    localparam logic signed [NW:0] SAT_MAX = {{(NW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [NW:0] SAT_MIN = {{(NW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_mc;

    logic                    w_accept;
    logic                    w_step;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_mc;
    logic [DATA_WIDTH:0]     w_mcp1;

    logic signed [DATA_WIDTH-1:0] w_lvl [2];
    logic signed [DATA_WIDTH-1:0] w_res [2];

    assign w_accept = (r_state == S_IDLE) && in_valid && en;
    assign w_step   = (r_state == S_DIV) && en;
    assign w_last   = w_step && (r_cnt == CNT_LAST);

    // A negative bound collapses the range to a single point at zero
    assign w_mc   = M[DATA_WIDTH-1] ? '0 : M;
    assign w_mcp1 = {1'b0, w_mc} + (DATA_WIDTH+1)'(1);

    assign w_lvl[0] = vqx;
    assign w_lvl[1] = vqy;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] w_qc;
            logic [DATA_WIDTH:0]   w_odd;
            logic [NW-1:0]         w_num;
            logic [NW-1:0]         r_num;
            logic [NW-1:0]         r_quo;
            logic [RW-1:0]         r_rem;
            logic [RW-1:0]         w_trial;
            logic                  w_qbit;
            logic [RW-1:0]         w_rem_next;
            logic [NW-1:0]         w_quo_full;
            logic signed [NW:0]    w_diff;
            logic signed [DATA_WIDTH-1:0] w_sat;

            always_comb begin
                w_qc = w_lvl[gi];
                if (w_lvl[gi][DATA_WIDTH-1]) begin
                    w_qc = '0;
                end else if (w_lvl[gi] >= L_LVL) begin
                    w_qc = L_TOP;
                end
            end

            assign w_odd = {w_qc, 1'b1};
            assign w_num = NW'(w_odd) * NW'(w_mcp1);

            // Remainder stays below L, so its top bit can be dropped before the shift
            assign w_trial    = {r_rem[RW-2:0], r_num[NW-1]};
            assign w_qbit     = (w_trial >= L_DIV);
            assign w_rem_next = w_qbit ? (w_trial - L_DIV) : w_trial;
            assign w_quo_full = {r_quo[NW-2:0], w_qbit};

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_num <= '0;
                    r_quo <= '0;
                    r_rem <= '0;
                end else if (w_accept) begin
                    r_num <= w_num;
                    r_quo <= '0;
                    r_rem <= '0;
                end else if (w_step) begin
                    r_num <= {r_num[NW-2:0], 1'b0};
                    r_quo <= w_quo_full;
                    r_rem <= w_rem_next;
                end
            end

            assign w_diff = $signed({1'b0, w_quo_full})
                          - $signed({{(NW-DATA_WIDTH+1){1'b0}}, r_mc});

            always_comb begin
                w_sat = w_diff[DATA_WIDTH-1:0];
                if (w_diff > SAT_MAX) begin
                    w_sat = SAT_MAX[DATA_WIDTH-1:0];
                end else if (w_diff < SAT_MIN) begin
                    w_sat = SAT_MIN[DATA_WIDTH-1:0];
                end
            end

            assign w_res[gi] = w_sat;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = en && rstn;
                if (en && in_valid) begin
                    w_state_next = S_DIV;
                end
            end
            S_DIV: begin
                if (w_last) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = rstn;
                if (en && out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_mc  <= '0;
            vdx   <= '0;
            vdy   <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_mc  <= w_mc;
        end else if (w_step) begin
            r_cnt <= w_last ? '0 : (r_cnt + CW'(1));
            if (w_last) begin
                vdx <= w_res[0];
                vdy <= w_res[1];
            end
        end
    end

endmodule

// File: tb/tb_dequantization.sv
// Bench for dequantization: fixed vectors, randomized pairs against an arithmetic
// model, and hand sequences for back-pressure, clock-enable stalls and mid-divide reset.
module tb_dequantization;

    localparam int DW = 16;
    localparam int L  = 6;
    localparam int NW = 2 * DW;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 en;
    logic signed [DW-1:0] M;
    logic signed [DW-1:0] vqx;
    logic signed [DW-1:0] vqy;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] vdx;
    logic signed [DW-1:0] vdy;
    logic                 out_valid;
    logic                 out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dequantization #(.DATA_WIDTH(DW), .L(L)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .M         (M),
        .vqx       (vqx),
        .vqy       (vqy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vdx       (vdx),
        .vdy       (vdy),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic signed [DW-1:0] m;
        logic signed [DW-1:0] qx;
        logic signed [DW-1:0] qy;
        int                   ex;
        int                   ey;
    } vec_t;

    vec_t vecs [6];

    // Bin-centre reconstruction straight from the arithmetic definition
    function automatic int model(input int m, input int q);
        longint mc, qc, n, v;
        mc = (m < 0) ? 0 : m;
        qc = (q < 0) ? 0 : ((q >= L) ? L - 1 : q);
        n  = (2 * qc + 1) * (mc + 1);
        v  = (n / L) - mc;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return int'(v);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send_pair(input logic signed [DW-1:0] m, input logic signed [DW-1:0] qx,
                             input logic signed [DW-1:0] qy);
        int k;
        k = 0;
        @(negedge clk);
        M = m; vqx = qx; vqy = qy; in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("accept_wait", (k < 100) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < start + 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic run_pair(input string name, input logic signed [DW-1:0] m,
                            input logic signed [DW-1:0] qx, input logic signed [DW-1:0] qy,
                            input int ex, input int ey);
        int lat;
        send_pair(m, qx, qy);
        wait_result(0, lat);
        check({name, "_latency"}, lat, NW);
        check({name, "_vdx"}, vdx, ex);
        check({name, "_vdy"}, vdy, ey);
        $display("%s: M=%0d vqx=%0d vqy=%0d -> vdx=%0d vdy=%0d lat=%0d", name, m, qx, qy, vdx, vdy, lat);
        release_result();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;
        logic signed [DW-1:0] rm, rx, ry;

        vecs[0] = '{16'sd100,   16'sd0, 16'sd5,  -84,    85};
        vecs[1] = '{16'sd100,   16'sd2, 16'sd3,  -16,    17};
        vecs[2] = '{16'sd100,   16'sd9, -16'sd4,  85,   -84};
        vecs[3] = '{-16'sd7,    16'sd0, 16'sd0,   0,     0};
        vecs[4] = '{16'sd0,     16'sd5, 16'sd4,   1,     1};
        vecs[5] = '{16'sd32767, 16'sd0, 16'sd5,  -27306, 27307};

        rstn = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        M = '0; vqx = '0; vqy = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_vdx", vdx, 0);
        check("rst_vdy", vdy, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        $display("reset: in_ready=%0d out_valid=%0d vdx=%0d vdy=%0d", in_ready, out_valid, vdx, vdy);

        for (int i = 0; i < 6; i++) begin
            run_pair($sformatf("vec%0d", i), vecs[i].m, vecs[i].qx, vecs[i].qy, vecs[i].ex, vecs[i].ey);
        end

        for (int i = 0; i < 24; i++) begin
            rm = DW'($urandom);
            if (i % 3 == 0) begin
                rx = DW'($urandom);
                ry = DW'($urandom);
            end else begin
                rx = DW'(int'($urandom_range(0, 12)) - 3);
                ry = DW'(int'($urandom_range(0, 12)) - 3);
            end
            run_pair($sformatf("rnd%0d", i), rm, rx, ry, model(rm, rx), model(rm, ry));
        end

        // Back-pressure in HOLD, with a competing input that must be ignored
        send_pair(16'sd100, 16'sd1, 16'sd4);
        wait_result(0, lat);
        check("bp_latency", lat, NW);
        check("bp_vdx", vdx, model(100, 1));
        check("bp_vdy", vdy, model(100, 4));
        @(negedge clk);
        M = 16'sd5; vqx = 16'sd0; vqy = 16'sd0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_vdx", vdx, model(100, 1));
            check("bp_hold_vdy", vdy, model(100, 4));
        end
        @(negedge clk);
        in_valid = 1'b0; en = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("en_low_hold_valid", out_valid, 1);
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        check("idle_keep_vdx", vdx, model(100, 1));
        $display("backpressure: M=100 vqx=1 vqy=4 -> vdx=%0d vdy=%0d", vdx, vdy);
        @(negedge clk);
        out_ready = 1'b0;

        // Clock-enable stall mid-divide stretches latency by the stall length
        send_pair(16'sd250, 16'sd3, 16'sd1);
        lat = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        en = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
            check("stall_out_valid", out_valid, 0);
            check("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        en = 1'b1;
        wait_result(lat, lat);
        check("stall_latency", lat, NW + 5);
        check("stall_vdx", vdx, model(250, 3));
        check("stall_vdy", vdy, model(250, 1));
        $display("stall: M=250 vqx=3 vqy=1 -> vdx=%0d vdy=%0d lat=%0d", vdx, vdy, lat);
        release_result();

        // Reset mid-divide aborts the pair and clears the outputs
        send_pair(16'sd100, 16'sd5, 16'sd0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_vdx", vdx, 0);
        check("abort_vdy", vdy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("abort_no_result", seen, 0);
        check("abort_idle", in_ready, 1);
        $display("abort: out_valid_seen=%0d in_ready=%0d", seen, in_ready);

        run_pair("recover", 16'sd100, 16'sd2, 16'sd3, -16, 17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
